debug_register_dumper: RTL and testbench

//  Debug-unit reader for the ID-stage register file debug port.
//  On a start request with the pipeline halted, it sweeps register addresses 0..CANT_REGISTROS-1.
//  For each address it drives the read address, waits for data, captures the 32-bit word and

---
 rtl/debug_register_dumper.sv | 108 ++++++++++
 tb/tb_debug_register_dumper.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_register_dumper.sv
// Debug-port register dumper: sweeps the register file, captures each word and
// streams it MSB-first as bytes over a valid/ready handshake to the UART transmitter.
//
// state   | meaning
// IDLE    | waiting for i_start
// WAIT_RD | read address driven, counting down until the read data is settled
// SEND    | presenting the captured word byte by byte
// DONE    | one-cycle completion pulse, then back to IDLE
module debug_register_dumper #(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BYTES          = CANT_BITS_REGISTROS / 8,
  parameter int READ_WAIT           = 2,
  localparam int AW = (CANT_REGISTROS > 1) ? $clog2(CANT_REGISTROS) : 1
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  output logic [AW-1:0]                  o_reg_read_addr,
  input  logic [CANT_BITS_REGISTROS-1:0] i_reg_data,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam int IW = (CANT_BYTES > 1) ? $clog2(CANT_BYTES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(READ_WAIT - 1);
  localparam logic [IW-1:0] LAST_BYTE = IW'(CANT_BYTES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CANT_REGISTROS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RD, SEND, DONE} state_t;

  state_t                         state;
  logic [CANT_BITS_REGISTROS-1:0] captured;
  logic [CANT_BITS_REGISTROS-1:0] captured_next;
  logic [IW-1:0]                  byte_idx;
  logic [CW-1:0]                  wait_cnt;

  // The captured word is shifted as bytes go out, so the byte on the wire is always the top byte.
  assign captured_next = captured << 8;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      o_reg_read_addr <= '0;
      o_tx_data       <= '0;
      o_tx_valid      <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      captured        <= '0;
      byte_idx        <= '0;
      wait_cnt        <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state           <= WAIT_RD;
            o_reg_read_addr <= '0;
            wait_cnt        <= WAIT_LOAD;
            o_busy          <= 1'b1;
          end
        end
        WAIT_RD: begin
          if (wait_cnt == '0) begin
            captured <= i_reg_data;
            state    <= SEND;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        SEND: begin
          if (!o_tx_valid) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= captured[CANT_BITS_REGISTROS-1 -: 8];
          end else if (i_tx_ready) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx  <= byte_idx + 1'b1;
              captured  <= captured_next;
              o_tx_data <= captured_next[CANT_BITS_REGISTROS-1 -: 8];
            end else begin
              byte_idx   <= '0;
              o_tx_valid <= 1'b0;
              if (o_reg_read_addr != LAST_ADDR) begin
                o_reg_read_addr <= o_reg_read_addr + 1'b1;
                wait_cnt        <= WAIT_LOAD;
                state           <= WAIT_RD;
              end else begin
                o_reg_read_addr <= '0;
                o_busy          <= 1'b0;
                o_done          <= 1'b1;
                state           <= DONE;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_register_dumper.sv
// Bench for debug_register_dumper: a register-file image defines the expected byte
// stream, and a per-cycle monitor checks handshakes, ordering, holding and completion.
module tb_debug_register_dumper;
  localparam int NREG = 32;
  localparam int NB   = 4;
  localparam int RW   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [4:0]  addr;
  logic [31:0] rdata;
  logic [7:0]  txd;
  logic        txv, busy, done;

  logic [31:0] regs [NREG];
  assign rdata = regs[addr];

  always #5 clk = ~clk;

  debug_register_dumper #(
    .CANT_REGISTROS(NREG), .CANT_BITS_REGISTROS(32), .CANT_BYTES(NB), .READ_WAIT(RW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .o_reg_read_addr(addr),
    .i_reg_data(rdata), .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(ready),
    .o_busy(busy), .o_done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int   byte_count = 0, done_count = 0, busy_cycles = 0;
  bit   seen_valid = 0;
  time  t_first_valid = 0, t_done = 0, t0 = 0;
  logic [7:0] prev_data = '0;
  bit   prev_hold = 0;
  bit   rand_ready = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference stream: every register in address order, each word MSB byte first.
  function automatic void push_dump();
    for (int r = 0; r < NREG; r++)
      for (int b = NB - 1; b >= 0; b--)
        exp_q.push_back(regs[r][8*b +: 8]);
  endfunction

  always @(posedge clk) begin
    #1;
    ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (busy) busy_cycles++;
      if (txv && !seen_valid) begin
        seen_valid = 1;
        t_first_valid = $time;
      end
      if (prev_hold) check("hold_stable", 32'({txv, txd}), 32'({1'b1, prev_data}));
      if (txv) check("busy_while_valid", 32'(busy), 32'd1);
      if (txv && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got byte %0h with %0d already accepted, expected none", txd, byte_count);
        end else begin
          check("byte", 32'(txd), 32'(exp_q.pop_front()));
        end
        got.push_back(txd);
        byte_count++;
      end
      if (done) begin
        done_count++;
        t_done = $time;
      end
      prev_hold = txv && !ready;
      prev_data = txd;
    end
  end

  task automatic clear_model();
    exp_q.delete();
    got.delete();
    byte_count = 0;
    done_count = 0;
    busy_cycles = 0;
    seen_valid = 0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pulse_start(input bit accepted);
    if (accepted) begin
      push_dump();
      seen_valid = 0;
      busy_cycles = 0;
    end
    start = 1'b1;
    @(posedge clk);
    if (accepted) t0 = $time;
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    int d0 = done_count;
    while (done_count == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_count == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no o_done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_bytes(input int count, input int budget);
    int n = 0;
    while (byte_count < count && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (byte_count < count) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: got %0d bytes, expected %0d", byte_count, count);
    end
  endtask

  task automatic check_end_of_dump(string tag);
    check({tag, "_bytes"}, 32'(byte_count), 32'(NREG * NB));
    check({tag, "_done_count"}, 32'(done_count), 32'd1);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle"}, 32'({busy, txv}), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = 32'h01010101 * i;
    regs[3] = 32'hDEADBEEF;

    // Ready held high: latency, total duration, byte order, start during DONE ignored.
    reset_dut();
    check("reset_outputs", 32'({addr, txd, txv, busy, done}), 32'd0);
    rand_ready = 0;
    pulse_start(1);
    repeat (NREG * (RW + 1 + NB)) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("first_valid_latency", 32'(int'((t_first_valid - t0 - 5) / 10)), 32'(RW + 1));
    check("done_edge", 32'(int'((t_done - t0 - 5) / 10)), 32'(NREG * (RW + 1 + NB)));
    check("busy_cycles", 32'(busy_cycles), 32'(NREG * (RW + 1 + NB)));
    check("r5_b0", 32'(got[20]), 32'h05);
    check("r5_b3", 32'(got[23]), 32'h05);
    check("r3_b0", 32'(got[12]), 32'hDE);
    check("r3_b1", 32'(got[13]), 32'hAD);
    check("r3_b2", 32'(got[14]), 32'hBE);
    check("r3_b3", 32'(got[15]), 32'hEF);
    check_end_of_dump("t1");

    // Random backpressure.
    reset_dut();
    rand_ready = 1;
    pulse_start(1);
    wait_done(5000);
    repeat (5) @(posedge clk);
    #1;
    check_end_of_dump("t3");

    // Start re-pulsed mid-dump is ignored.
    reset_dut();
    pulse_start(1);
    wait_bytes(40, 3000);
    pulse_start(0);
    wait_done(5000);
    repeat (20) @(posedge clk);
    #1;
    check_end_of_dump("t4");

    // Reset mid-dump aborts at once; a new dump restarts from register 0.
    reset_dut();
    pulse_start(1);
    wait_bytes(70, 3000);
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({addr, txd, txv, busy, done}), 32'd0);
    clear_model();
    regs[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    rst = 1'b0;
    pulse_start(1);
    wait_done(5000);
    repeat (5) @(posedge clk);
    #1;
    check("restart_b0", 32'(got[0]), 32'hDE);
    check("restart_b3", 32'(got[3]), 32'hEF);
    check_end_of_dump("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
